// File: rtl/qk_inst_sequencer_if.sv
// ---------------------------------------------------------------------------
// qk_inst_sequencer_if
//   Handshake and control bundle between a host vector stream, the
//   qk_inst_sequencer and the fullchip it drives.
//
//   start            host -> seq   pass request pulse
//   in_valid         host -> seq   Q/K vector present on mem_in0/mem_in1
//   in_ready         seq  -> host  vector accepted this cycle
//   inst[16:0]       seq  -> chip  instruction word
//   div              seq  -> chip  sfp divider phase strobe
//   *_clk_en         seq  -> chip  block clock enables
//   busy, done       seq  -> host  pass status
//
//   modport master : host side (drives start/in_valid)
//   modport slave  : sequencer side
// ---------------------------------------------------------------------------
interface qk_inst_sequencer_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] inst;
    logic        div;
    logic        mac_array_clk_en;
    logic        sfp_row_clk_en;
    logic        kmem_clk_en;
    logic        qmem_clk_en;
    logic        busy;
    logic        done;

    modport master (
        output start, in_valid,
        input  in_ready, inst, div, mac_array_clk_en, sfp_row_clk_en,
               kmem_clk_en, qmem_clk_en, busy, done
    );

    modport slave (
        input  start, in_valid,
        output in_ready, inst, div, mac_array_clk_en, sfp_row_clk_en,
               kmem_clk_en, qmem_clk_en, busy, done
    );
endinterface

// File: rtl/qk_inst_sequencer.sv
// ---------------------------------------------------------------------------
// qk_inst_sequencer
//   Issues the instruction word, div strobe and clock enables for one full
//   attention pass per start: Q write, K write, K load, execute, ofifo drain,
//   then normalise/writeback into pmem.
//
//   Ports:
//     clk    single clock
//     reset  synchronous, active-high
//     bus    qk_inst_sequencer_if.slave (start, in_valid/in_ready, inst,
//            div, clock enables, busy, done)
//
//   Optional build macro: SEQ_PMEM_READBACK_EN
//     Adds a READBACK phase after NORM reading pmem 0..total_cycle-1
//     (inst[1] = pmem_rd). Without it inst[1] is tied to 0.
//
//   All outputs are registered from the next state so they line up with the
//   state register, except in_ready/qmem_wr/kmem_wr which follow in_valid
//   combinationally in the write phases.
// ---------------------------------------------------------------------------
module qk_inst_sequencer #(
    parameter int total_cycle = 8,   // Q vectors per pass, total_cycle+2 <= 15
    parameter int col         = 8,   // K vectors, col <= 16
    parameter int LOAD_GAP    = 10,
    parameter int EXEC_DRAIN  = 9,
    parameter int SFP_WAIT    = 5
) (
    input  logic                clk,
    input  logic                reset,
    qk_inst_sequencer_if.slave  bus
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXPH  = imax(imax(imax(total_cycle + 2, col + 1), imax(LOAD_GAP, EXEC_DRAIN)),
                                 imax(SFP_WAIT, 2 * total_cycle));
    localparam int CW_RAW = $clog2(MAXPH) + 1;
    // NORM derives pmem_add from cnt[4:1], so keep at least 5 bits
    localparam int CW     = (CW_RAW < 5) ? 5 : CW_RAW;

    localparam logic [CW-1:0] TC_LAST  = CW'(total_cycle - 1);
    localparam logic [CW-1:0] KWR_LAST = CW'(col - 1);
    localparam logic [CW-1:0] KLD_LAST = CW'(col);
    localparam logic [CW-1:0] GAP_LAST = CW'(LOAD_GAP - 1);
    localparam logic [CW-1:0] EXE_LAST = CW'(total_cycle + 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(EXEC_DRAIN - 1);
    localparam logic [CW-1:0] SW_LAST  = CW'(SFP_WAIT - 1);
    localparam logic [CW-1:0] NRM_LAST = CW'(2 * total_cycle - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [3:0] {
        IDLE, QWR, KWR, KLOAD, KTAIL, KOFF, GAP, EXEC,
        DRAIN, OFIFO, SWAIT, NORM, READBACK, DONE
    } state_t;

    typedef struct packed {
        logic       ofifo_rd;
        logic [3:0] qk_add;
        logic [3:0] p_add;
        logic       execute;
        logic       load;
        logic       qmem_rd;
        logic       kmem_rd;
        logic       pmem_wr;
        logic       div;
        logic       mac_en;
        logic       sfp_en;
        logic       kclk_en;
        logic       qclk_en;
        logic       busy;
        logic       done;
    } out_t;

    localparam out_t OUT_RST = '{kclk_en: 1'b1, qclk_en: 1'b1, default: '0};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // write index or cycle-within-phase
    out_t          out_q, out_d;
    logic          qmem_wr, kmem_wr, pmem_rd;

    // Output decode for a given (state, phase counter)
    function automatic out_t decode(input state_t s, input logic [CW-1:0] c);
        out_t o;
        o = '0;
        case (s)
            IDLE:     begin o.kclk_en = 1'b1; o.qclk_en = 1'b1; end
            QWR:      begin o.busy = 1'b1; o.qclk_en = 1'b1; o.qk_add = c[3:0]; end
            KWR:      begin o.busy = 1'b1; o.kclk_en = 1'b1; o.qk_add = c[3:0]; end
            KLOAD: begin
                o.busy = 1'b1; o.kclk_en = 1'b1; o.mac_en = 1'b1; o.load = 1'b1;
                // kmem read lags load by one cycle, so address trails c by one
                o.kmem_rd = (c != '0);
                o.qk_add  = (c > ONE) ? (c[3:0] - 4'd1) : 4'd0;
            end
            KTAIL:    begin o.busy = 1'b1; o.kclk_en = 1'b1; o.mac_en = 1'b1; o.load = 1'b1; end
            KOFF,
            GAP,
            DRAIN:    begin o.busy = 1'b1; o.mac_en = 1'b1; end
            EXEC: begin
                o.busy = 1'b1; o.qclk_en = 1'b1; o.mac_en = 1'b1;
                o.execute = 1'b1; o.qmem_rd = 1'b1; o.qk_add = c[3:0];
            end
            OFIFO:    begin o.busy = 1'b1; o.sfp_en = 1'b1; o.ofifo_rd = 1'b1; end
            SWAIT:    begin o.busy = 1'b1; o.sfp_en = 1'b1; end
            NORM: begin
                // i = c+1: div on odd i, address advances every second cycle
                o.busy = 1'b1; o.sfp_en = 1'b1; o.pmem_wr = 1'b1;
                o.div   = ~c[0];
                o.p_add = c[4:1];
            end
            READBACK: begin o.busy = 1'b1; o.sfp_en = 1'b1; o.p_add = c[3:0]; end
            DONE:     begin o.busy = 1'b1; o.done = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    // Next state / phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = QWR;
            end
            QWR: begin
                cnt_d = cnt_q;
                if (bus.in_valid) begin
                    if (cnt_q == TC_LAST) begin state_d = KWR; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            KWR: begin
                cnt_d = cnt_q;
                if (bus.in_valid) begin
                    if (cnt_q == KWR_LAST) begin state_d = KLOAD; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            KLOAD: if (cnt_q == KLD_LAST) begin state_d = KTAIL; cnt_d = '0; end
            KTAIL: begin state_d = KOFF; cnt_d = '0; end
            KOFF:  begin state_d = GAP;  cnt_d = '0; end
            GAP:   if (cnt_q == GAP_LAST) begin state_d = EXEC;  cnt_d = '0; end
            EXEC:  if (cnt_q == EXE_LAST) begin state_d = DRAIN; cnt_d = '0; end
            DRAIN: if (cnt_q == DRN_LAST) begin state_d = OFIFO; cnt_d = '0; end
            OFIFO: if (cnt_q == TC_LAST)  begin state_d = SWAIT; cnt_d = '0; end
            SWAIT: if (cnt_q == SW_LAST)  begin state_d = NORM;  cnt_d = '0; end
            NORM: if (cnt_q == NRM_LAST) begin
                cnt_d = '0;
`ifdef SEQ_PMEM_READBACK_EN
                state_d = READBACK;
`else
                state_d = DONE;
`endif
            end
            READBACK: if (cnt_q == TC_LAST) begin state_d = DONE; cnt_d = '0; end
            DONE:    begin state_d = IDLE; cnt_d = '0; end
            default: begin state_d = IDLE; cnt_d = '0; end
        endcase
    end

    always_comb out_d = decode(state_d, cnt_d);

`ifdef SEQ_PMEM_READBACK_EN
    logic pmem_rd_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= OUT_RST;
`ifdef SEQ_PMEM_READBACK_EN
            pmem_rd_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef SEQ_PMEM_READBACK_EN
            pmem_rd_q <= (state_d == READBACK);
`endif
        end
    end

`ifdef SEQ_PMEM_READBACK_EN
    assign pmem_rd = pmem_rd_q;
`else
    assign pmem_rd = 1'b0;
`endif

    // Write strobes follow in_valid directly so a stalled host costs no write
    assign bus.in_ready = (state_q == QWR) || (state_q == KWR);
    assign qmem_wr      = (state_q == QWR) && bus.in_valid;
    assign kmem_wr      = (state_q == KWR) && bus.in_valid;

    assign bus.inst = {out_q.ofifo_rd, out_q.qk_add, out_q.p_add, out_q.execute, out_q.load,
                       out_q.qmem_rd, qmem_wr, out_q.kmem_rd, kmem_wr, pmem_rd, out_q.pmem_wr};
    assign bus.div              = out_q.div;
    assign bus.mac_array_clk_en = out_q.mac_en;
    assign bus.sfp_row_clk_en   = out_q.sfp_en;
    assign bus.kmem_clk_en      = out_q.kclk_en;
    assign bus.qmem_clk_en      = out_q.qclk_en;
    assign bus.busy             = out_q.busy;
    assign bus.done             = out_q.done;

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qk_inst_sequencer
//   Directed bench for qk_inst_sequencer at default parameters. Cycle k is
//   counted from the edge that samples start (k=1 is the first QWR cycle);
//   outputs are sampled 2 time units after each rising edge.
//   Expected timeline (no stall): QWR 1..8, KWR 9..16, KLOAD 17..25,
//   KTAIL 26, KOFF 27, GAP 28..37, EXEC 38..47, DRAIN 48..56, OFIFO 57..64,
//   SWAIT 65..69, NORM 70..85, [READBACK 86..93], DONE 86 (94).
// ---------------------------------------------------------------------------
module tb_qk_inst_sequencer;

`ifdef SEQ_PMEM_READBACK_EN
    localparam int RB = 8;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qk_inst_sequencer_if bus();

    qk_inst_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // trace of one pass
    int qwr_add[$], kwr_add[$], krd_add[$], ex_add[$], padd[$], prd_add[$], stall_add[$];
    int load_n, qrd_n, ofifo_n, pwr_n, mac_qk, sfp_n, sfp_first, sfp_last, busy_n, done_k, stall_wr;
    logic [15:0] divv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_inst"},   bus.inst, 0);
        chk({tag, "_div"},    bus.div, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_done"},   bus.done, 0);
        chk({tag, "_rdy"},    bus.in_ready, 0);
        chk({tag, "_mac"},    bus.mac_array_clk_en, 0);
        chk({tag, "_sfp"},    bus.sfp_row_clk_en, 0);
        chk({tag, "_kclk"},   bus.kmem_clk_en, 1);
        chk({tag, "_qclk"},   bus.qmem_clk_en, 1);
    endtask

    // abort_at: cycle at which reset is raised (0 = never)
    // stall: hold in_valid low for k=5..7; restart_at: extra start pulse
    task automatic run_pass(input int abort_at, input bit stall, input int restart_at);
        logic [16:0] in;
        qwr_add.delete(); kwr_add.delete(); krd_add.delete(); ex_add.delete();
        padd.delete(); prd_add.delete(); stall_add.delete();
        load_n = 0; qrd_n = 0; ofifo_n = 0; pwr_n = 0; mac_qk = 0; sfp_n = 0;
        sfp_first = 0; sfp_last = 0; busy_n = 0; done_k = 0; stall_wr = 0; divv = '0;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            bus.in_valid = !(stall && k >= 5 && k <= 7);
            bus.start    = (k == restart_at);
            #1;
            in = bus.inst;
            if (k == abort_at) begin
                chk("pre_abort_execute", in[7], 1);
                chk("pre_abort_add", in[15:12], 2);
                reset = 1'b1;
                @(posedge clk); #1;
                chk_idle("abort");
                reset = 1'b0;
                bus.start = 1'b0;
                return;
            end
            if (in[4]) qwr_add.push_back(int'(in[15:12]));
            if (in[2]) kwr_add.push_back(int'(in[15:12]));
            if (in[6]) load_n++;
            if (in[3]) krd_add.push_back(int'(in[15:12]));
            if (in[7]) ex_add.push_back(int'(in[15:12]));
            if (in[5]) qrd_n++;
            if (in[16]) ofifo_n++;
            if (in[0]) begin
                pwr_n++;
                divv = {divv[14:0], bus.div};
                padd.push_back(int'(in[11:8]));
            end
            if (in[1]) prd_add.push_back(int'(in[11:8]));
            if (bus.in_ready && bus.mac_array_clk_en) mac_qk++;
            if (bus.sfp_row_clk_en) begin
                sfp_n++;
                if (sfp_first == 0) sfp_first = k;
                sfp_last = k;
            end
            if (bus.busy && !bus.done) busy_n++;
            if (stall && k >= 5 && k <= 7) begin
                stall_add.push_back(int'(in[15:12]));
                stall_wr += int'(in[4]);
            end
            if (bus.done) done_k = k;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_writes();
        chk("qwr_n", qwr_add.size(), 8);
        chk("kwr_n", kwr_add.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("qwr_add", qget(qwr_add, i), i);
            chk("kwr_add", qget(kwr_add, i), i);
        end
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("idle");

        // Pass 1: reset mid-EXEC at k=40
        run_pass(40, 1'b0, 0);

        // Pass 2: full clean pass after the abort
        run_pass(0, 1'b0, 0);
        chk("done_k", done_k, 86 + RB);
        chk("busy_n", busy_n, 85 + RB);
        chk_writes();
        chk("load_n", load_n, 10);
        chk("krd_n", krd_add.size(), 8);
        for (int i = 0; i < 8; i++) chk("krd_add", qget(krd_add, i), i);
        chk("exec_n", ex_add.size(), 10);
        chk("qrd_n", qrd_n, 10);
        for (int i = 0; i < 10; i++) chk("exec_add", qget(ex_add, i), i);
        chk("mac_in_wr", mac_qk, 0);
        chk("ofifo_n", ofifo_n, 8);
        chk("pwr_n", pwr_n, 16);
        chk("div_pat", divv, 16'hAAAA);
        for (int i = 0; i < 16; i++) chk("pmem_add", qget(padd, i), i / 2);
        chk("sfp_n", sfp_n, 29 + RB);
        chk("sfp_first", sfp_first, 57);
        chk("sfp_last", sfp_last, 85 + RB);
        chk("prd_n", prd_add.size(), RB);
        for (int i = 0; i < RB; i++) chk("prd_add", qget(prd_add, i), i);
        chk_idle("post_done");

        // Pass 3: 3-cycle host stall after 4th Q vector, start re-pulsed while busy
        run_pass(0, 1'b1, 20);
        chk("stall_done_k", done_k, 89 + RB);
        chk_writes();
        chk("stall_wr", stall_wr, 0);
        chk("stall_len", stall_add.size(), 3);
        for (int i = 0; i < 3; i++) chk("stall_add", qget(stall_add, i), 4);
        repeat (5) @(posedge clk);
        #1;
        chk_idle("no_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qk_inst_sequencer.md
Name: qk_inst_sequencer

Overview:
- On-chip controller that generates the 17-bit `inst` word, the `div` strobe and the four clock enables that drive `fullchip`. This moves instruction issue from the bench into hardware.
- Sits between a host vector stream (valid/ready) and `fullchip`. Runs one complete attention pass per `start`: Q write, K write, K load, execute, ofifo drain, then normalise/writeback into pmem.

Parameters:
- total_cycle, 8, number of Q vectors per pass; constraint total_cycle+2 <= 15.
- col, 8, number of K vectors / dot-product columns; constraint col <= 16.
- LOAD_GAP, 10, idle cycles between K load and execute.
- EXEC_DRAIN, 9, idle cycles after execute before the ofifo read.
- SFP_WAIT, 5, idle cycles between the ofifo read and normalisation.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a pass when sampled in IDLE
- in_valid  in  1  host has a Q/K vector on mem_in0/mem_in1
- in_ready  out  1  sequencer accepts the vector this cycle
- inst  out  17  [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- div  out  1  divider phase strobe for the sfp (MCP-2)
- mac_array_clk_en  out  1
- sfp_row_clk_en  out  1
- kmem_clk_en  out  1
- qmem_clk_en  out  1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset, and the IDLE state:
  - state goes to IDLE; all inst bits, div, mac/sfp enables, busy and done are 0.
  - kmem_clk_en and qmem_clk_en are 1.
  - Reset asserted mid-pass aborts to IDLE on the next edge; no partial cleanup sequence is issued.
- Output timing: all outputs are registered (Moore), except in_ready, qmem_wr and kmem_wr, which are combinational.
- IDLE: start=1 moves to QWR. start is ignored while busy.
- QWR:
  - in_ready=1; qmem_wr = in_valid; qkmem_add = write index.
  - The index increments only on in_valid & in_ready; if in_valid is low, the sequencer stalls with no write.
  - After total_cycle writes: go to KWR; qkmem_add returns to 0.
- KWR: same handshake with kmem_wr, for col vectors. qmem_clk_en=0 in this state.
- KLOAD (col+1 cycles, counter c from 0):
  - load=1 throughout.
  - kmem_rd=1 for c >= 1.
  - qkmem_add = 0 for c <= 1, else c-1.
- KTAIL: one cycle with load=1, kmem_rd=0, add=0.
- KOFF: one cycle with load=0.
- GAP: LOAD_GAP cycles with all strobes 0.
- EXEC (total_cycle+2 cycles, counter c): execute=1, qmem_rd=1, qkmem_add=c.
- DRAIN: EXEC_DRAIN cycles with all strobes 0; add=0.
- OFIFO: total_cycle cycles with ofifo_rd=1.
- SWAIT: SFP_WAIT cycles with all strobes 0.
- NORM (2*total_cycle cycles, i from 1):
  - pmem_wr=1 throughout.
  - div=1 on odd i, 0 on even i.
  - pmem_add increments on each odd i > 1, so the final pmem_add is total_cycle-1.
- DONE: one cycle with done=1 and all strobes 0; pmem_add returns to 0; then IDLE.
- Clock enables by state:
  - qmem_clk_en=1 in IDLE, QWR, EXEC.
  - kmem_clk_en=1 in IDLE, KWR, KLOAD, KTAIL.
  - mac_array_clk_en=1 from KLOAD through DRAIN.
  - sfp_row_clk_en=1 from OFIFO through NORM (and READBACK when the optional feature is built in).
- Address arithmetic: 4-bit address fields, no wrap within legal parameters. Counters are sized as $clog2 of the longest phase + 1.
- Pass length: with in_valid held high, the states occupy 8+8+11+10+10+9+8+5+16 = 85 cycles. DONE is entered at the 86th edge after the edge that samples start.

Optional Feature:
- SEQ_PMEM_READBACK_EN, when defined: after NORM, a READBACK state issues pmem_rd=1 for total_cycle cycles with pmem_add = 0 .. total_cycle-1, then goes to DONE. This adds total_cycle cycles to the pass.
- When undefined: NORM goes directly to DONE, and inst[1] is tied to 0.

Test Plan:
- Reset mid-EXEC (cycle 40): next cycle inst=0, div=0, busy=0, kmem/qmem_clk_en=1, state IDLE. A subsequent start runs a full pass normally.
- start with in_valid continuously high, defaults:
  - 8 qmem_wr at adds 0..7, then 8 kmem_wr at adds 0..7.
  - done pulse exactly 86 edges after start; busy high for 85 cycles.
- in_valid low for 3 cycles after the 4th Q vector: qmem_wr=0 and qkmem_add holds at 4 during the stall. Pass completes 3 cycles later than the unstalled run; all 8 addresses are still written.
- KLOAD/EXEC trace:
  - load high for 10 cycles; kmem_rd high for 8 cycles with adds 0..7.
  - execute/qmem_rd high for 10 cycles with adds 0..9.
  - mac_array_clk_en low during QWR and KWR.
- NORM trace: 16 pmem_wr cycles; div pattern 1,0,1,0…; pmem_add sequence 0,0,1,1,…,7,7. sfp_row_clk_en high only during OFIFO through NORM.
- With SEQ_PMEM_READBACK_EN defined: 8 pmem_rd cycles at adds 0..7 after NORM; done at edge 94. A second start pulse asserted while busy is ignored.
